// File: rtl/spad_sp_arbiter_pkg.sv
// Shared types for the scratchpad arbiter: grant selector and round-robin pointer encoding.
package spad_sp_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    localparam logic RR_PTR_RD  = 1'b0;
    localparam logic RR_PTR_WR  = 1'b1;
    localparam logic RR_PTR_RST = RR_PTR_RD;

endpackage

// File: rtl/spad_arb_rsp_slot.sv
// One-entry read response slot: data arrives from the scratchpad one cycle after issue,
// is shown combinationally, and is captured into the hold register if the consumer stalls.
module spad_arb_rsp_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_issue_i,
    input  logic                  rsp_ready_i,
    input  logic [DATA_WIDTH-1:0] spad_rdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  slot_free_o
);

    logic                  rsp_vld_q, rsp_vld_d;
    logic                  held_q, held_d;
    logic [DATA_WIDTH-1:0] hold_dat_q, hold_dat_d;

    always_comb begin
        rsp_vld_d  = rsp_vld_q & ~rsp_ready_i;
        held_d     = 1'b0;
        hold_dat_d = hold_dat_q;
        if (rd_issue_i) begin
            // Fresh read: its data comes straight from the scratchpad next cycle.
            rsp_vld_d = 1'b1;
            held_d    = 1'b0;
        end else if (rsp_vld_q && !rsp_ready_i) begin
            held_d = 1'b1;
            if (!held_q) begin
                hold_dat_d = spad_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_vld_q  <= 1'b0;
            held_q     <= 1'b0;
            hold_dat_q <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            held_q     <= held_d;
            hold_dat_q <= hold_dat_d;
        end
    end

    assign rsp_valid_o = rsp_vld_q;
    assign rsp_data_o  = held_q ? hold_dat_q : spad_rdata_i;
    assign slot_free_o = ~rsp_vld_q | rsp_ready_i;

endmodule

// File: rtl/spad_sp_arbiter.sv
// Per-cycle read/write arbiter for a single-port scratchpad; read data returns one cycle after grant.
// Reads stall only while the response slot is full; optional SPAD_ARB_RR_EN selects round-robin, else reads win.
module spad_sp_arbiter
    import spad_sp_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  spad_re_o,
    output logic                  spad_we_o,
    output logic [ADDR_WIDTH-1:0] spad_addr_o,
    output logic [DATA_WIDTH-1:0] spad_wdata_o,
    input  logic [DATA_WIDTH-1:0] spad_rdata_i,
    output logic                  busy_o
);

    gnt_e gnt;
    logic slot_free;
    logic rd_elig, wr_elig;

    assign rd_elig = rd_valid_i & slot_free;
    assign wr_elig = wr_valid_i;

`ifdef SPAD_ARB_RR_EN
    logic rr_q, rr_d;

    // Pointer only moves on contended grants so an idle requester cannot steal a turn.
    always_comb begin
        rr_d = rr_q;
        if (!rst_i && rd_elig && wr_elig) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= RR_PTR_RST;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (!rst_i) begin
            if (rd_elig && wr_elig) begin
`ifdef SPAD_ARB_RR_EN
                gnt = (rr_q == RR_PTR_RD) ? GNT_RD : GNT_WR;
`else
                gnt = GNT_RD;
`endif
            end else if (rd_elig) begin
                gnt = GNT_RD;
            end else if (wr_elig) begin
                gnt = GNT_WR;
            end
        end
    end

    assign rd_ready_o   = (gnt == GNT_RD);
    assign wr_ready_o   = (gnt == GNT_WR);
    assign spad_re_o    = (gnt == GNT_RD);
    assign spad_we_o    = (gnt == GNT_WR);
    assign spad_addr_o  = (gnt == GNT_RD) ? rd_addr_i :
                          (gnt == GNT_WR) ? wr_addr_i : '0;
    assign spad_wdata_o = (gnt == GNT_WR) ? wr_data_i : '0;

    spad_arb_rsp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_slot (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_issue_i   (gnt == GNT_RD),
        .rsp_ready_i  (rsp_ready_i),
        .spad_rdata_i (spad_rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .slot_free_o  (slot_free)
    );

    assign busy_o = rsp_valid_o | wr_valid_i | rd_valid_i;

endmodule

// File: tb/tb_spad_sp_arbiter.sv
// Bench: directed scenarios plus randomized traffic against a transaction-level model with a behavioural scratchpad.
module tb_spad_sp_arbiter;

    logic       clk;
    logic       rst;
    logic       wr_v, rd_v, rsp_rdy;
    logic [9:0] wr_a, rd_a;
    logic [7:0] wr_d;
    logic       wr_ready_o, rd_ready_o, rsp_valid_o, spad_re, spad_we, busy_o;
    logic [7:0] rsp_data_o, spad_wdata, spad_rdata;
    logic [9:0] spad_addr;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic [7:0] exp_q [$];
    logic       ptr;
    int         n_chk = 0;
    int         n_bad = 0;

    spad_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_valid_i   (wr_v),
        .wr_ready_o   (wr_ready_o),
        .wr_addr_i    (wr_a),
        .wr_data_i    (wr_d),
        .rd_valid_i   (rd_v),
        .rd_ready_o   (rd_ready_o),
        .rd_addr_i    (rd_a),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_rdy),
        .rsp_data_o   (rsp_data_o),
        .spad_re_o    (spad_re),
        .spad_we_o    (spad_we),
        .spad_addr_o  (spad_addr),
        .spad_wdata_o (spad_wdata),
        .spad_rdata_i (spad_rdata),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port scratchpad: registered read data.
    always @(posedge clk) begin
        if (spad_we) mem[spad_addr] <= spad_wdata;
        if (spad_re) spad_rdata <= mem[spad_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic r, input logic wv, input logic [9:0] wa, input logic [7:0] wd,
                        input logic rv, input logic [9:0] ra, input logic rr,
                        output logic wacc, output logic racc);
        logic pend, rd_e, wr_e, g_rd, g_wr;
        @(negedge clk);
        rst = r; wr_v = wv; wr_a = wa; wr_d = wd; rd_v = rv; rd_a = ra; rsp_rdy = rr;
        #1;
        pend = (exp_q.size() != 0);
        rd_e = rv && (!pend || rr);
        wr_e = wv;
        g_rd = 1'b0;
        g_wr = 1'b0;
        if (!r) begin
            if (rd_e && wr_e) begin
`ifdef SPAD_ARB_RR_EN
                if (ptr == 1'b0) g_rd = 1'b1; else g_wr = 1'b1;
                ptr = ~ptr;
`else
                g_rd = 1'b1;
`endif
            end else begin
                g_rd = rd_e;
                g_wr = wr_e;
            end
        end
        chk("rd_ready", rd_ready_o, g_rd);
        chk("wr_ready", wr_ready_o, g_wr);
        chk("spad_re", spad_re, g_rd);
        chk("spad_we", spad_we, g_wr);
        if (g_rd) chk("rd_addr", spad_addr, ra);
        if (g_wr) begin
            chk("wr_addr", spad_addr, wa);
            chk("wr_data", spad_wdata, wd);
        end
        if (!r) begin
            chk("rsp_valid", rsp_valid_o, pend);
            chk("busy", busy_o, pend || wv || rv);
            if (pend) chk("rsp_data", rsp_data_o, exp_q[0]);
        end
        if (r) begin
            exp_q.delete();
            ptr = 1'b0;
        end else begin
            if (pend && rr) void'(exp_q.pop_front());
            if (g_rd) exp_q.push_back(ref_mem[ra]);
            if (g_wr) ref_mem[wa] = wd;
        end
        wacc = g_wr;
        racc = g_rd;
    endtask

    initial begin
        logic wa_acc, ra_acc;
        int   cnt;
        logic hv_w, hv_r;
        logic nwv, nrv, nr;
        logic [9:0] nwa, nra;
        logic [7:0] nwd;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        spad_rdata = 8'h00;
        ptr = 1'b0;
        rst = 1'b1; wr_v = 0; rd_v = 0; rsp_rdy = 0; wr_a = 0; rd_a = 0; wr_d = 0;

        step(1, 1, 10'd1, 8'h11, 1, 10'd1, 1, wa_acc, ra_acc);
        step(1, 0, 0, 0, 0, 0, 0, wa_acc, ra_acc);
        step(0, 0, 0, 0, 0, 0, 0, wa_acc, ra_acc);

        // Write then read the same address.
        step(0, 1, 10'd5, 8'h3C, 0, 0, 1, wa_acc, ra_acc);
        chk("wr5_acc", wa_acc, 1'b1);
        step(0, 0, 0, 0, 1, 10'd5, 1, wa_acc, ra_acc);
        step(0, 0, 0, 0, 0, 0, 1, wa_acc, ra_acc);
        chk("rd5_data_direct", rsp_data_o, 8'h3C);

        // Preload 0..7 and stream eight reads.
        for (int i = 0; i < 8; i++) step(0, 1, 10'(i), 8'(8'h10 + i), 0, 0, 1, wa_acc, ra_acc);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 1, 10'(i), 1, wa_acc, ra_acc);
            cnt += int'(ra_acc);
        end
        chk("stream_rd_cnt", cnt, 8);
        step(0, 0, 0, 0, 0, 0, 1, wa_acc, ra_acc);

        // Stalled consumer for three cycles.
        step(0, 0, 0, 0, 1, 10'd3, 1, wa_acc, ra_acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 10'd4, 0, wa_acc, ra_acc);
        step(0, 0, 0, 0, 1, 10'd4, 1, wa_acc, ra_acc);
        chk("release_rd_acc", ra_acc, 1'b1);
        step(0, 0, 0, 0, 0, 0, 1, wa_acc, ra_acc);

        // Both requesters valid continuously.
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 10'(20 + i), 8'(8'hA0 + i), 1, 10'(i), 1, wa_acc, ra_acc);
            cnt += int'(wa_acc);
        end
`ifdef SPAD_ARB_RR_EN
        chk("contend_wr_cnt", cnt, 3);
`else
        chk("contend_wr_cnt", cnt, 0);
`endif
        step(0, 0, 0, 0, 0, 0, 1, wa_acc, ra_acc);

        // Slot full: write wins regardless of the pointer.
        step(0, 0, 0, 0, 1, 10'd1, 1, wa_acc, ra_acc);
        step(0, 1, 10'd30, 8'h5A, 1, 10'd2, 0, wa_acc, ra_acc);
        chk("slot_full_wr", wa_acc, 1'b1);
        step(0, 0, 0, 0, 0, 0, 1, wa_acc, ra_acc);

        // Reset with a response pending.
        step(0, 0, 0, 0, 1, 10'd30, 1, wa_acc, ra_acc);
        step(1, 1, 10'd31, 8'h77, 1, 10'd2, 0, wa_acc, ra_acc);
        step(0, 1, 10'd31, 8'h77, 1, 10'd2, 1, wa_acc, ra_acc);
        chk("post_rst_rd_first", ra_acc, 1'b1);
        step(0, 0, 0, 0, 0, 0, 1, wa_acc, ra_acc);

        // Randomized traffic obeying the request hold rules.
        hv_w = 0; hv_r = 0;
        nwv = 0; nrv = 0; nwa = 0; nra = 0; nwd = 0;
        for (int c = 0; c < 3000; c++) begin
            nr = ($urandom_range(99) == 0);
            if (!hv_w) begin
                nwv = ($urandom_range(1) == 1);
                nwa = 10'($urandom_range(15));
                nwd = 8'($urandom);
            end
            if (!hv_r) begin
                nrv = ($urandom_range(4) < 3);
                nra = 10'($urandom_range(15));
            end
            step(nr, nwv, nwa, nwd, nrv, nra, ($urandom_range(3) != 0), wa_acc, ra_acc);
            hv_w = nwv && !wa_acc && !nr;
            hv_r = nrv && !ra_acc && !nr;
        end
        step(0, 0, 0, 0, 0, 0, 1, wa_acc, ra_acc);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
